ahb_mem_slave: RTL
==================

// Module: ahb_mem_slave
// PURPOSE
// - Word-addressed SRAM bus slave; sits directly downstream of data_path's address decoder and master mux.
// - Consumes its decoder select, the address, write data and the transfer strobe.
// - Produces the rdata/ready/resp triple that feeds the slave-response mux (rdinN/rdyN/respN).
// - Inserts a programmable number of wait states; flags misaligned or out-of-range accesses with a 2-cycle ERROR.
// PARAMETERS
// ADDR_WIDTH   16   bus address width
// DATA_WIDTH   32   bus data width
// MEM_DEPTH    256  words of storage (power of 2, <= 2^(ADDR_WIDTH-2))
// WAIT_STATES  2    wait cycles inserted before each OKAY data phase (0..15)
// PORTS
// clk      in   1           system clock, rising edge
// rst      in   1           asynchronous reset, active-high
// hsel     in   1           slave select from address decoder
// trans    in   1           master drives a valid transfer this cycle
// addr     in   ADDR_WIDTH  byte address (address phase)
// write    in   1           1 = write, 0 = read (address phase)
// wdata    in   DATA_WIDTH  write data (data phase)
// rdata    out  DATA_WIDTH  read data, valid when ready=1 in a read data phase
// ready    out  1           1 = current data phase completes this cycle / slave accepts address
// resp     out  2           00 OKAY, 01 ERROR (10 RETRY, 11 SPLIT never generated)
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, ready=1, resp=00, rdata=0, wait counter=0; memory array not reset.
// - Accept: on a rising clk with ready=1 & hsel=1 & trans=1, latch addr, write and word index addr[log2(MEM_DEPTH)+1:2].
// - Decode error: addr[1:0]!=0 or addr[ADDR_WIDTH-1:2] >= MEM_DEPTH.
// - FSM states:
//   IDLE -> accept & error -> ERR1; accept & WAIT_STATES>0 -> WAIT; accept & WAIT_STATES==0 -> DATA.
//   WAIT: ready=0, resp=00; counts WAIT_STATES cycles, then -> DATA.
//   DATA: ready=1, resp=00; read drives mem[idx] on rdata this cycle; write stores wdata into mem[idx] at this cycle's rising edge.
//     Next state: new accept in same cycle -> pipelined as from IDLE; else IDLE.
//   ERR1: ready=0, resp=01 -> ERR2.
//   ERR2: ready=1, resp=01, no memory access; accepts a new address like DATA.
// - Latency (accept edge to completing data phase): WAIT_STATES+1 cycles. Back-to-back with WAIT_STATES=0 gives 1 word/cycle.
// - IDLE: ready=1, resp=00, rdata holds its last value.
// - Select/strobe rules:
//   hsel=0 or trans=0 while ready=1: no transfer, next state IDLE.
//   hsel/trans ignored while ready=0.
// - Read-after-write to the same word in consecutive transfers returns the newly written data (write lands before next data phase).
// - Index wraps never: out-of-range is ERROR, not aliased.
// - rst asserted mid-transfer: aborts immediately, pending write is discarded, outputs return to reset values.
// TESTING
// 1. Reset: rst=1 mid-WAIT -> ready=1, resp=00, rdata=0 next sample; a subsequent read of the aborted write address returns the old value.
// 2. Write 0x0000_0237 to addr 0x0008, then read 0x0008 (WAIT_STATES=2) -> ready low 2 cycles each; read data phase rdata=0x237, resp=00.
// 3. Misaligned addr 0x000A -> ERR1 (ready=0, resp=01), then ERR2 (ready=1, resp=01); memory unchanged.
// 4. Out-of-range addr 0x0400 (MEM_DEPTH=256) -> same 2-cycle ERROR; the next valid transfer completes with OKAY.
// 5. WAIT_STATES=0, back-to-back writes to 0x0,0x4,0x8 then reads -> ready stays 1, one word per cycle, correct data.
// 6. hsel=0 with trans=1, and hsel=1 with trans=0 -> no state change, no write, ready=1, resp=00.

Source files
------------

// File: rtl/ahb_mem_slave_if.sv
// Bus-side signal bundle between the master/decoder fabric and ahb_mem_slave.
// The master modport drives the address/data phase; the slave returns rdata/ready/resp.
interface ahb_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic                  trans;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic [1:0]            resp;

  modport master (
    output hsel, trans, addr, write, wdata,
    input  rdata, ready, resp
  );

  modport slave (
    input  hsel, trans, addr, write, wdata,
    output rdata, ready, resp
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// Word-addressed SRAM bus slave with programmable wait states and a two-cycle
// ERROR response for misaligned or out-of-range addresses.
module ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input logic            clk,
  input logic            rst,
  ahb_mem_slave_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                state_q;
  logic                  ready_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  accept;
  logic                  dec_err;
  logic                  hi_bits_set;
  logic                  mem_we;
  logic [IDX_W-1:0]      idx_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Any address bit above the word index means the access is beyond the array.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_range
    assign hi_bits_set = |bus.addr[ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_full
    assign hi_bits_set = 1'b0;
  end

  assign accept  = ready_q & bus.hsel & bus.trans;
  assign dec_err = (bus.addr[1:0] != 2'b00) | hi_bits_set;
  assign idx_d   = bus.addr[IDX_W+1:2];
  assign mem_we  = (state_q == ST_DATA) & write_q;

  // A read entering DATA straight off a write data phase to the same word must
  // see the word being written on this very edge, not the stale array content.
  assign rd_idx  = (state_q == ST_WAIT) ? idx_q : idx_d;
  assign rd_word = (mem_we && (rd_idx == idx_q)) ? bus.wdata : mem_q[rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_DATA;
            ready_q <= 1'b1;
            if (!write_q) rdata_q <= rd_word;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all present ready=1 and may take a new address.
          if (accept) begin
            idx_q   <= idx_d;
            write_q <= bus.write;
            if (dec_err) begin
              state_q <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= RESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              state_q <= ST_DATA;
              ready_q <= 1'b1;
              resp_q  <= RESP_OKAY;
              if (!bus.write) rdata_q <= rd_word;
            end else begin
              state_q <= ST_WAIT;
              ready_q <= 1'b0;
              resp_q  <= RESP_OKAY;
              cnt_q   <= WS_LAST;
            end
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing it would forbid SRAM
  // inference and is not needed since contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= bus.wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.resp  = resp_q;
endmodule
